// File: rtl/decode_stage_pkg.sv
// Shared decode types: opcode/funct constants, ALU and writeback encodings,
// and the packed control bundle carried from decode to execute.
package decode_stage_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ARIMM  = 7'b0010011;
    localparam logic [6:0] OP_ARITH  = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_SR   = 3'b101;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SLT, ALU_BOOL, ALU_SHIFT, ALU_MULDIV, ALU_PASSB
    } alu_op_t;

    typedef enum logic [1:0] { WB_ALU, WB_MEM, WB_PC4 } wb_sel_t;

    typedef struct packed {
        alu_op_t     alu_op;
        logic        alu_sub;
        logic [1:0]  bool_op;      // funct3[1:0]: 00 xor, 10 or, 11 and
        logic        shift_right;
        logic        shift_arith;
        logic        a_pc;
        logic        b_imm;
        logic        cmp_signed;
        logic [2:0]  br_type;
        logic        cond_br;
        logic        jump;
        logic        mem_we;
        logic [1:0]  ld_size;
        logic        ld_signed;
        wb_sel_t     wb_sel;
        logic        wb_we;
        logic [2:0]  muldiv_op;
    } decode_ctrl_t;

    typedef struct packed {
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [4:0]   rd;
        logic [31:0]  imm;
        decode_ctrl_t ctrl;
        logic         illegal;
    } dec_bundle_t;

endpackage

// File: rtl/decode_stage_if.sv
// Upstream/downstream handshake and decoded bundle of the decode stage.
interface decode_stage_if #(parameter int PC_WIDTH = 32);
    import decode_stage_pkg::*;

    logic                i_valid;
    logic                o_ready;
    logic [31:0]         i_inst;
    logic [PC_WIDTH-1:0] i_pc;
    logic                i_flush;
    logic                o_valid;
    logic                i_ready;
    logic [PC_WIDTH-1:0] o_pc;
    logic [4:0]          o_rs1;
    logic [4:0]          o_rs2;
    logic [4:0]          o_rd;
    logic [31:0]         o_imm;
    decode_ctrl_t        o_ctrl;
    logic                o_illegal;

    modport master (
        output i_valid, i_inst, i_pc, i_flush, i_ready,
        input  o_ready, o_valid, o_pc, o_rs1, o_rs2, o_rd, o_imm, o_ctrl, o_illegal
    );
    modport slave (
        input  i_valid, i_inst, i_pc, i_flush, i_ready,
        output o_ready, o_valid, o_pc, o_rs1, o_rs2, o_rd, o_imm, o_ctrl, o_illegal
    );
endinterface

// File: rtl/decode_logic.sv
// Combinational RV32I decoder. DECODE_MEXT_EN enables the M-extension
// (funct7=0000001) encodings; otherwise they decode as illegal.
module decode_logic
    import decode_stage_pkg::*;
(
    input  logic [31:0] i_inst,
    output dec_bundle_t o_dec
);
    logic [6:0]   opc, f7;
    logic [2:0]   f3;
    logic [4:0]   rd;
    logic [31:0]  imm_i, imm_s, imm_b, imm_u, imm_j, imm;
    decode_ctrl_t c;
    logic         ill, wb;

    assign opc   = i_inst[6:0];
    assign f3    = i_inst[14:12];
    assign f7    = i_inst[31:25];
    assign rd    = i_inst[11:7];
    assign imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
    assign imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign imm_u = {i_inst[31:12], 12'b0};
    assign imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

    always_comb begin
        c   = '0;
        ill = 1'b0;
        wb  = 1'b0;
        imm = imm_i;
        case (opc)
            OP_LUI:   begin c.alu_op = ALU_PASSB; c.b_imm = 1'b1; wb = 1'b1; imm = imm_u; end
            OP_AUIPC: begin c.a_pc = 1'b1; c.b_imm = 1'b1; wb = 1'b1; imm = imm_u; end
            OP_JAL: begin
                c.jump = 1'b1; c.a_pc = 1'b1; c.b_imm = 1'b1;
                c.wb_sel = WB_PC4; wb = 1'b1; imm = imm_j;
            end
            OP_JALR: begin
                c.jump = 1'b1; c.b_imm = 1'b1; c.wb_sel = WB_PC4; wb = 1'b1;
                ill = (f3 != 3'b000);
            end
            OP_BRANCH: begin
                c.cond_br = 1'b1; c.br_type = f3; c.alu_op = ALU_SLT;
                c.cmp_signed = ~f3[1]; imm = imm_b;
                ill = (f3[2:1] == 2'b01);
            end
            OP_LOAD: begin
                c.b_imm = 1'b1; c.wb_sel = WB_MEM; wb = 1'b1;
                c.ld_size = f3[1:0]; c.ld_signed = ~f3[2];
                ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            OP_STORE: begin
                c.mem_we = 1'b1; c.b_imm = 1'b1; c.ld_size = f3[1:0]; imm = imm_s;
                ill = (f3 > 3'b010);
            end
            OP_ARIMM, OP_ARITH: begin
                c.b_imm = (opc == OP_ARIMM);
                wb = 1'b1;
                case (f3)
                    F3_ADD:          c.alu_op = ALU_ADD;
                    F3_SLT, F3_SLTU: begin c.alu_op = ALU_SLT; c.cmp_signed = (f3 == F3_SLT); end
                    F3_SLL, F3_SR: begin
                        c.alu_op      = ALU_SHIFT;
                        c.shift_right = f3[2];
                        c.shift_arith = f3[2] & f7[5];
                    end
                    default: begin c.alu_op = ALU_BOOL; c.bool_op = f3[1:0]; end
                endcase
                if (opc == OP_ARIMM) begin
                    if (f3 == F3_SLL)     ill = (f7 != F7_BASE);
                    else if (f3 == F3_SR) ill = (f7 != F7_BASE) && (f7 != F7_ALT);
                end else if (f7 == F7_MULDIV) begin
`ifdef DECODE_MEXT_EN
                    c           = '0;
                    c.alu_op    = ALU_MULDIV;
                    c.muldiv_op = f3;
`else
                    ill = 1'b1;
`endif
                end else if (f7 == F7_ALT) begin
                    c.alu_sub = (f3 == F3_ADD);
                    ill       = (f3 != F3_ADD) && (f3 != F3_SR);
                end else begin
                    ill = (f7 != F7_BASE);
                end
            end
            OP_FENCE, OP_SYSTEM: ;
            default: ill = 1'b1;
        endcase

        // Illegal instructions must never commit side effects downstream.
        c.wb_we = wb && (rd != 5'd0) && !ill;
        if (ill) begin
            c.mem_we  = 1'b0;
            c.cond_br = 1'b0;
            c.jump    = 1'b0;
        end

        o_dec.rs1     = i_inst[19:15];
        o_dec.rs2     = i_inst[24:20];
        o_dec.rd      = rd;
        o_dec.imm     = imm;
        o_dec.ctrl    = c;
        o_dec.illegal = ill;
    end
endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: decodes on input, holds result in an output register
// backed by one skid entry so o_ready can be registered.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int PC_WIDTH = 32
)(
    input logic           i_clk,
    input logic           i_rst,
    decode_stage_if.slave bus
);
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_FULL  = 2'b01;
    localparam logic [1:0] ST_SKID  = 2'b10;

    logic [1:0]          state, state_nxt;
    logic                ready_q, acc, drn;
    dec_bundle_t         dec, out_q, skid_q;
    logic [PC_WIDTH-1:0] out_pc_q, skid_pc_q;

    decode_logic u_dec (.i_inst(bus.i_inst), .o_dec(dec));

    assign acc = bus.i_valid && ready_q;
    assign drn = (state != ST_EMPTY) && bus.i_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (acc) state_nxt = ST_FULL;
            ST_FULL: begin
                if (acc && !drn)      state_nxt = ST_SKID;
                else if (!acc && drn) state_nxt = ST_EMPTY;
            end
            ST_SKID:  if (drn) state_nxt = ST_FULL;
            default:  state_nxt = ST_EMPTY;
        endcase
        if (bus.i_flush) state_nxt = ST_EMPTY;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= ST_EMPTY;
            ready_q   <= 1'b1;
            out_q     <= '0;
            skid_q    <= '0;
            out_pc_q  <= '0;
            skid_pc_q <= '0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt != ST_SKID);
            if (!bus.i_flush) begin
                if (state == ST_SKID) begin
                    if (drn) begin
                        out_q    <= skid_q;
                        out_pc_q <= skid_pc_q;
                    end
                end else if (acc && (state == ST_EMPTY || drn)) begin
                    out_q    <= dec;
                    out_pc_q <= bus.i_pc;
                end else if (acc) begin
                    // FULL and stalled: park the new instruction behind the output.
                    skid_q    <= dec;
                    skid_pc_q <= bus.i_pc;
                end
            end
        end
    end

    assign bus.o_ready   = ready_q;
    assign bus.o_valid   = (state != ST_EMPTY);
    assign bus.o_pc      = out_pc_q;
    assign bus.o_rs1     = out_q.rs1;
    assign bus.o_rs2     = out_q.rs2;
    assign bus.o_rd      = out_q.rd;
    assign bus.o_imm     = out_q.imm;
    assign bus.o_ctrl    = out_q.ctrl;
    assign bus.o_illegal = out_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, backpressure/skid, flush, reset.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    decode_stage_if #(.PC_WIDTH(32)) bus ();
    decode_stage #(.PC_WIDTH(32)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Present one instruction for one cycle; returns at the next negedge with it in the output reg.
    task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
        bus.i_valid = 1'b1;
        bus.i_inst  = inst;
        bus.i_pc    = pc;
        @(negedge i_clk);
        bus.i_valid = 1'b0;
    endtask

    // inst, expected {illegal, wb_we, mem_we}
    localparam int NV = 13;
    logic [31:0] v_inst [NV] = '{
        32'h402081B3, 32'h0020A423, 32'h00003063, 32'hFE209EE3, 32'h010000EF,
        32'h00000013, 32'hFFFFFFFF, 32'h00003083, 32'h000010E7, 32'h00003023,
        32'h401090B3, 32'h40109093, 32'hFFC0A283 };
    logic [2:0]  v_exp [NV] = '{
        3'b010, 3'b001, 3'b100, 3'b000, 3'b010,
        3'b000, 3'b100, 3'b100, 3'b100, 3'b100,
        3'b100, 3'b100, 3'b010 };

    initial begin
        bus.i_valid = 1'b0;
        bus.i_inst  = '0;
        bus.i_pc    = '0;
        bus.i_flush = 1'b0;
        bus.i_ready = 1'b1;

        #3;
        chk("rst valid",   bus.o_valid, 0);
        chk("rst illegal", bus.o_illegal, 0);
        chk("rst ctrl",    bus.o_ctrl, 0);
        chk("rst pc",      bus.o_pc, 0);
        chk("rst imm",     bus.o_imm, 0);
        chk("rst rd",      bus.o_rd, 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst ready", bus.o_ready, 1);

        // addi x1,x0,5
        issue(32'h00500093, 32'h100);
        chk("addi valid",   bus.o_valid, 1);
        chk("addi pc",      bus.o_pc, 32'h100);
        chk("addi rd",      bus.o_rd, 1);
        chk("addi imm",     bus.o_imm, 5);
        chk("addi wb_we",   bus.o_ctrl.wb_we, 1);
        chk("addi illegal", bus.o_illegal, 0);
        @(negedge i_clk);
        chk("addi drained", bus.o_valid, 0);

        for (int i = 0; i < NV; i++) begin
            issue(v_inst[i], 32'h1000 + 4 * i);
            chk($sformatf("v%0d illegal", i), bus.o_illegal, v_exp[i][2]);
            chk($sformatf("v%0d wb_we", i),   bus.o_ctrl.wb_we, v_exp[i][1]);
            chk($sformatf("v%0d mem_we", i),  bus.o_ctrl.mem_we, v_exp[i][0]);
            chk($sformatf("v%0d pc", i),      bus.o_pc, 32'h1000 + 4 * i);
            case (i)
                0: chk("sub alu_sub", bus.o_ctrl.alu_sub, 1);
                1: chk("sw imm", bus.o_imm, 8);
                3: begin
                    chk("bne imm", bus.o_imm, 32'hFFFFFFFC);
                    chk("bne cond_br", bus.o_ctrl.cond_br, 1);
                end
                4: begin
                    chk("jal imm", bus.o_imm, 16);
                    chk("jal wb_sel", bus.o_ctrl.wb_sel, WB_PC4);
                end
                8: chk("bad jalr jump", bus.o_ctrl.jump, 0);
                12: chk("lw imm", bus.o_imm, 32'hFFFFFFFC);
                default: ;
            endcase
        end

        // srai x1,x1,2
        issue(32'h4020D093, 32'h2000);
        chk("srai right",   bus.o_ctrl.shift_right, 1);
        chk("srai arith",   bus.o_ctrl.shift_arith, 1);
        chk("srai shamt",   bus.o_imm[4:0], 2);
        chk("srai illegal", bus.o_illegal, 0);

        // mul x0,x1,x2
        issue(32'h02208033, 32'h2004);
        chk("mul wb_we", bus.o_ctrl.wb_we, 0);
`ifdef DECODE_MEXT_EN
        chk("mul illegal", bus.o_illegal, 0);
        chk("mul op", bus.o_ctrl.alu_op, ALU_MULDIV);
`else
        chk("mul illegal", bus.o_illegal, 1);
        chk("mul muldiv_op", bus.o_ctrl.muldiv_op, 0);
`endif
        @(negedge i_clk);

        // Backpressure: three back-to-back inputs against a stalled consumer
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b1; bus.i_inst = 32'h00100093; bus.i_pc = 32'h200;
        @(negedge i_clk);
        chk("bp ready a", bus.o_ready, 1);
        chk("bp pc a",    bus.o_pc, 32'h200);
        bus.i_inst = 32'h00200113; bus.i_pc = 32'h204;
        @(negedge i_clk);
        chk("bp ready b", bus.o_ready, 0);
        chk("bp hold pc", bus.o_pc, 32'h200);
        chk("bp hold imm", bus.o_imm, 1);
        bus.i_inst = 32'h00300193; bus.i_pc = 32'h208;
        @(negedge i_clk);
        chk("bp stall ready", bus.o_ready, 0);
        chk("bp stall pc",    bus.o_pc, 32'h200);
        bus.i_ready = 1'b1;
        @(negedge i_clk);
        chk("bp out b pc",  bus.o_pc, 32'h204);
        chk("bp out b imm", bus.o_imm, 2);
        chk("bp ready re",  bus.o_ready, 1);
        @(negedge i_clk);
        chk("bp out c pc", bus.o_pc, 32'h208);
        chk("bp out c rd", bus.o_rd, 3);
        bus.i_valid = 1'b0;
        @(negedge i_clk);
        chk("bp empty", bus.o_valid, 0);

        // Flush while in SKID with a live input
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b1; bus.i_inst = 32'h00400213; bus.i_pc = 32'h300;
        @(negedge i_clk);
        bus.i_inst = 32'h00500293; bus.i_pc = 32'h304;
        @(negedge i_clk);
        chk("fl skid ready", bus.o_ready, 0);
        bus.i_flush = 1'b1; bus.i_inst = 32'h00600313; bus.i_pc = 32'h308;
        @(negedge i_clk);
        chk("fl valid", bus.o_valid, 0);
        chk("fl ready", bus.o_ready, 1);
        bus.i_flush = 1'b0; bus.i_valid = 1'b0; bus.i_ready = 1'b1;
        @(negedge i_clk);
        chk("fl no leak", bus.o_valid, 0);

        // Flush from EMPTY discards the same-cycle input
        bus.i_valid = 1'b1; bus.i_flush = 1'b1;
        @(negedge i_clk);
        bus.i_valid = 1'b0; bus.i_flush = 1'b0;
        chk("fl empty in", bus.o_valid, 0);

        // Reset while holding output and skid
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b1; bus.i_inst = 32'h00400213; bus.i_pc = 32'h400;
        @(negedge i_clk);
        bus.i_inst = 32'h00500293; bus.i_pc = 32'h404;
        @(negedge i_clk);
        bus.i_valid = 1'b0;
        #2 i_rst = 1'b1;
        #1;
        chk("mid rst valid", bus.o_valid, 0);
        chk("mid rst pc",    bus.o_pc, 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        bus.i_ready = 1'b1;
        @(negedge i_clk);
        chk("mid rst after", bus.o_valid, 0);
        chk("mid rst ready", bus.o_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
